// File: rtl/msrv32_trap_pkg.sv
// Shared encodings for the machine-mode trap sequencer.
// Optional WFI stall state is enabled by MSRV32_WFI_STALL_EN.
package msrv32_trap_pkg;

`ifdef MSRV32_WFI_STALL_EN
    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3,
        ST_WAIT_IRQ    = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_RESET       = 2'd0,
        ST_OPERATING   = 2'd1,
        ST_TRAP_TAKEN  = 2'd2,
        ST_TRAP_RETURN = 2'd3
    } state_e;
`endif

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_BREAK          = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    localparam logic [3:0] IRQ_SW    = 4'd3;
    localparam logic [3:0] IRQ_TIMER = 4'd7;
    localparam logic [3:0] IRQ_EXT   = 4'd11;

endpackage

// File: rtl/msrv32_trap_cause_enc.sv
// Combinational trap priority encoder: enabled interrupts first, then exceptions.
// Independent of MSRV32_WFI_STALL_EN.
module msrv32_trap_cause_enc
    import msrv32_trap_pkg::*;
(
    input  logic       mie_i,
    input  logic       meie_i,
    input  logic       mtie_i,
    input  logic       msie_i,
    input  logic       meip_i,
    input  logic       mtip_i,
    input  logic       msip_i,
    input  logic       illegal_i,
    input  logic       misaligned_instr_i,
    input  logic       misaligned_load_i,
    input  logic       misaligned_store_i,
    input  logic       ecall_i,
    input  logic       ebreak_i,
    output logic       valid_o,
    output logic       i_or_e_o,
    output logic [3:0] cause_o
);

    always_comb begin
        valid_o  = 1'b1;
        i_or_e_o = 1'b0;
        cause_o  = CAUSE_INSTR_MISALIGN;
        if (mie_i && meie_i && meip_i) begin
            i_or_e_o = 1'b1;
            cause_o  = IRQ_EXT;
        end else if (mie_i && msie_i && msip_i) begin
            i_or_e_o = 1'b1;
            cause_o  = IRQ_SW;
        end else if (mie_i && mtie_i && mtip_i) begin
            i_or_e_o = 1'b1;
            cause_o  = IRQ_TIMER;
        end else if (misaligned_instr_i) begin
            cause_o = CAUSE_INSTR_MISALIGN;
        end else if (illegal_i) begin
            cause_o = CAUSE_ILLEGAL;
        end else if (ebreak_i) begin
            cause_o = CAUSE_BREAK;
        end else if (ecall_i) begin
            cause_o = CAUSE_ECALL_M;
        end else if (misaligned_load_i) begin
            cause_o = CAUSE_LOAD_MISALIGN;
        end else if (misaligned_store_i) begin
            cause_o = CAUSE_STORE_MISALIGN;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/msrv32_trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer driving CSR updates and PC source.
// Define MSRV32_WFI_STALL_EN to add the wfi_in/stall_out ports and WAIT_IRQ state.
//
//   state          | meaning
//   ST_RESET       | boot hold: PC from boot vector, pipeline flushed
//   ST_OPERATING   | normal execution, traps and MRET accepted
//   ST_TRAP_TAKEN  | one cycle: write mepc/mcause, clear MIE, jump to vector
//   ST_TRAP_RETURN | one cycle: restore MIE, jump to mepc
//   ST_WAIT_IRQ    | (WFI build only) PC stalled until an enabled irq pends
module msrv32_trap_ctrl
    import msrv32_trap_pkg::*;
#(
    parameter int BOOT_HOLD_CYCLES = 1
) (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_n_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
`ifdef MSRV32_WFI_STALL_EN
    input  logic       wfi_in,
    output logic       stall_out,
`endif
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       instret_inc_out
);

    localparam logic [3:0] HOLD_LAST = 4'(BOOT_HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] cause_q, cause_d;
    logic       i_or_e_q, i_or_e_d;

    logic       enc_valid;
    logic       enc_i_or_e;
    logic [3:0] enc_cause;

    msrv32_trap_cause_enc u_cause_enc (
        .mie_i              (mie_in),
        .meie_i             (meie_in),
        .mtie_i             (mtie_in),
        .msie_i             (msie_in),
        .meip_i             (meip_in),
        .mtip_i             (mtip_in),
        .msip_i             (msip_in),
        .illegal_i          (illegal_instr_in),
        .misaligned_instr_i (misaligned_instr_in),
        .misaligned_load_i  (misaligned_load_in),
        .misaligned_store_i (misaligned_store_in),
        .ecall_i            (ecall_in),
        .ebreak_i           (ebreak_in),
        .valid_o            (enc_valid),
        .i_or_e_o           (enc_i_or_e),
        .cause_o            (enc_cause)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q  <= ST_RESET;
            hold_q   <= 4'd0;
            cause_q  <= 4'd0;
            i_or_e_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cause_q  <= cause_d;
            i_or_e_q <= i_or_e_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        cause_d         = cause_q;
        i_or_e_d        = i_or_e_q;
        trap_taken_out  = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        pc_src_out      = PC_BOOT;
        flush_out       = 1'b1;
        instret_inc_out = 1'b0;
`ifdef MSRV32_WFI_STALL_EN
        stall_out       = 1'b0;
`endif
        case (state_q)
            ST_RESET: begin
                hold_d = hold_q + 4'd1;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = 4'd0;
                    state_d = ST_OPERATING;
                end
            end
            ST_OPERATING: begin
                pc_src_out = PC_NEXT;
                flush_out  = 1'b0;
                // A trap wins over a simultaneous MRET (and WFI).
                if (enc_valid) begin
                    trap_taken_out = 1'b1;
                    cause_d        = enc_cause;
                    i_or_e_d       = enc_i_or_e;
                    state_d        = ST_TRAP_TAKEN;
                end else begin
                    instret_inc_out = 1'b1;
                    if (mret_in) begin
                        state_d = ST_TRAP_RETURN;
`ifdef MSRV32_WFI_STALL_EN
                    end else if (wfi_in) begin
                        state_d = ST_WAIT_IRQ;
`endif
                    end
                end
            end
            ST_TRAP_TAKEN: begin
                set_epc_out   = 1'b1;
                set_cause_out = 1'b1;
                mie_clear_out = 1'b1;
                pc_src_out    = PC_TRAP;
                state_d       = ST_OPERATING;
            end
            ST_TRAP_RETURN: begin
                mie_set_out = 1'b1;
                pc_src_out  = PC_EPC;
                state_d     = ST_OPERATING;
            end
`ifdef MSRV32_WFI_STALL_EN
            ST_WAIT_IRQ: begin
                pc_src_out = PC_NEXT;
                flush_out  = 1'b0;
                stall_out  = 1'b1;
                // Wake ignores mstatus.MIE; the trap itself still needs it.
                if ((meie_in && meip_in) || (msie_in && msip_in) || (mtie_in && mtip_in))
                    state_d = ST_OPERATING;
            end
`endif
            default: state_d = ST_RESET;
        endcase
    end

    assign cause_out  = cause_q;
    assign i_or_e_out = i_or_e_q;

endmodule

// File: tb/tb_msrv32_trap_ctrl.sv
// Scoreboard bench for msrv32_trap_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares.
module tb_msrv32_trap_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       illegal, mis_i, mis_l, mis_s, ecall, ebreak, mret;
    logic       mie, meie, mtie, msie, meip, mtip, msip;
    logic       trap_taken, set_epc, set_cause, i_or_e, mie_clear, mie_set, flush, instret;
    logic [3:0] cause;
    logic [1:0] pc_src;
`ifdef MSRV32_WFI_STALL_EN
    logic       stall;
`endif

    always #5 clk = ~clk;

    msrv32_trap_ctrl #(.BOOT_HOLD_CYCLES(1)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .illegal_instr_in       (illegal),
        .misaligned_instr_in    (mis_i),
        .misaligned_load_in     (mis_l),
        .misaligned_store_in    (mis_s),
        .ecall_in               (ecall),
        .ebreak_in              (ebreak),
        .mret_in                (mret),
        .mie_in                 (mie),
        .meie_in                (meie),
        .mtie_in                (mtie),
        .msie_in                (msie),
        .meip_in                (meip),
        .mtip_in                (mtip),
        .msip_in                (msip),
`ifdef MSRV32_WFI_STALL_EN
        .wfi_in                 (1'b0),
        .stall_out              (stall),
`endif
        .trap_taken_out         (trap_taken),
        .set_epc_out            (set_epc),
        .set_cause_out          (set_cause),
        .cause_out              (cause),
        .i_or_e_out             (i_or_e),
        .mie_clear_out          (mie_clear),
        .mie_set_out            (mie_set),
        .pc_src_out             (pc_src),
        .flush_out              (flush),
        .instret_inc_out        (instret)
    );

    typedef struct packed {
        logic       tt;
        logic       epc;
        logic       setc;
        logic [3:0] cause;
        logic       ioe;
        logic       mclr;
        logic       mset;
        logic [1:0] pc;
        logic       flush;
        logic       inst;
    } exp_t;

    localparam logic [13:0] ILL = 14'h2000, MISI = 14'h1000, MISL = 14'h0800, MISS = 14'h0400;
    localparam logic [13:0] ECL = 14'h0200, EBK = 14'h0100, MRT = 14'h0080, MIE = 14'h0040;
    localparam logic [13:0] MEIE = 14'h0020, MTIE = 14'h0010, MSIE = 14'h0008;
    localparam logic [13:0] MEIP = 14'h0004, MTIP = 14'h0002, MSIP = 14'h0001;
    localparam logic [13:0] NONE = 14'h0000;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic exp_t e_rst(input logic [3:0] c, input logic i);
        return '{tt:0, epc:0, setc:0, cause:c, ioe:i, mclr:0, mset:0, pc:2'b00, flush:1, inst:0};
    endfunction
    function automatic exp_t e_op(input logic t, input logic n, input logic [3:0] c, input logic i);
        return '{tt:t, epc:0, setc:0, cause:c, ioe:i, mclr:0, mset:0, pc:2'b11, flush:0, inst:n};
    endfunction
    function automatic exp_t e_tt(input logic [3:0] c, input logic i);
        return '{tt:0, epc:1, setc:1, cause:c, ioe:i, mclr:1, mset:0, pc:2'b10, flush:1, inst:0};
    endfunction
    function automatic exp_t e_tr(input logic [3:0] c, input logic i);
        return '{tt:0, epc:0, setc:0, cause:c, ioe:i, mclr:0, mset:1, pc:2'b01, flush:1, inst:0};
    endfunction

    task automatic step(input logic [13:0] v, input logic rst, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n = rst;
        {illegal, mis_i, mis_l, mis_s, ecall, ebreak, mret, mie, meie, mtie, msie, meip, mtip, msip} = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{tt:trap_taken, epc:set_epc, setc:set_cause, cause:cause, ioe:i_or_e,
                   mclr:mie_clear, mset:mie_set, pc:pc_src, flush:flush, inst:instret};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got %b required %b (tt,epc,setc,cause,ioe,mclr,mset,pc,flush,inst)",
                         nm, a, e);
            end
        end
    end

    typedef struct {
        logic [13:0] v;
        logic [3:0]  c;
        logic        i;
        string       nm;
    } prio_t;

    prio_t prio_tab[7];

    initial begin
        {illegal, mis_i, mis_l, mis_s, ecall, ebreak, mret, mie, meie, mtie, msie, meip, mtip, msip} = '0;
        prio_tab[0] = '{MIE|MEIE|MEIP|MSIE|MSIP|MTIE|MTIP|ILL, 4'd11, 1'b1, "prio_ext"};
        prio_tab[1] = '{MIE|MSIE|MSIP|MTIE|MTIP,               4'd3,  1'b1, "prio_sw"};
        prio_tab[2] = '{MISI|ILL|EBK|ECL|MISL|MISS,            4'd0,  1'b0, "prio_misi"};
        prio_tab[3] = '{EBK|ECL|MISL,                          4'd3,  1'b0, "prio_ebreak"};
        prio_tab[4] = '{ECL|MISL|MISS,                         4'd11, 1'b0, "prio_ecall"};
        prio_tab[5] = '{MISL|MISS,                             4'd4,  1'b0, "prio_load"};
        prio_tab[6] = '{MIE|MEIE|MSIP|MTIP|MISS,               4'd6,  1'b0, "prio_unenabled_irq"};

        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(e_rst(4'd0, 1'b0));
        name_q.push_back("in_reset");

        step(NONE, 1'b1, e_rst(4'd0, 1'b0), "boot_hold");
        step(NONE, 1'b1, e_op(1'b0, 1'b1, 4'd0, 1'b0), "first_operating");
        step(ILL,  1'b1, e_op(1'b1, 1'b0, 4'd0, 1'b0), "illegal_trap_taken");
        step(ILL,  1'b1, e_tt(4'd2, 1'b0), "illegal_entry_no_tt");
        step(NONE, 1'b1, e_op(1'b0, 1'b1, 4'd2, 1'b0), "illegal_back_op");

        step(MISS|MTIE|MTIP|MIE, 1'b1, e_op(1'b1, 1'b0, 4'd2, 1'b0), "store_irq_trap");
        step(NONE, 1'b1, e_tt(4'd7, 1'b1), "timer_beats_store");
        step(NONE, 1'b1, e_op(1'b0, 1'b1, 4'd7, 1'b1), "cause_hold_7");

        step(MISS|MTIE|MTIP, 1'b1, e_op(1'b1, 1'b0, 4'd7, 1'b1), "store_nomie_trap");
        step(NONE, 1'b1, e_tt(4'd6, 1'b0), "store_cause_6");
        step(MIE|MEIE|MTIP|MSIP, 1'b1, e_op(1'b0, 1'b1, 4'd6, 1'b0), "no_enabled_pending");

        step(MRT,  1'b1, e_op(1'b0, 1'b1, 4'd6, 1'b0), "mret_accept");
        step(MIE|MEIE|MEIP, 1'b1, e_tr(4'd6, 1'b0), "mret_return_no_irq");
        step(NONE, 1'b1, e_op(1'b0, 1'b1, 4'd6, 1'b0), "after_return");

        step(MRT|ECL, 1'b1, e_op(1'b1, 1'b0, 4'd6, 1'b0), "mret_ecall_trap");
        step(NONE, 1'b1, e_tt(4'd11, 1'b0), "ecall_wins_no_mie_set");
        step(NONE, 1'b1, e_op(1'b0, 1'b1, 4'd11, 1'b0), "after_ecall");

        for (int k = 0; k < 7; k++) begin
            logic [3:0] prev_c;
            logic       prev_i;
            prev_c = (k == 0) ? 4'd11 : prio_tab[k-1].c;
            prev_i = (k == 0) ? 1'b0  : prio_tab[k-1].i;
            step(prio_tab[k].v, 1'b1, e_op(1'b1, 1'b0, prev_c, prev_i), {prio_tab[k].nm, "_tt"});
            step(NONE, 1'b1, e_tt(prio_tab[k].c, prio_tab[k].i), prio_tab[k].nm);
        end
        step(NONE, 1'b1, e_op(1'b0, 1'b1, 4'd6, 1'b0), "after_prio");

        step(ILL,  1'b1, e_op(1'b1, 1'b0, 4'd6, 1'b0), "pre_reset_trap");
        step(NONE, 1'b0, e_rst(4'd0, 1'b0), "async_reset_in_trap");
        step(NONE, 1'b0, e_rst(4'd0, 1'b0), "reset_held");
        step(NONE, 1'b1, e_rst(4'd0, 1'b0), "reboot_hold");
        step(NONE, 1'b1, e_op(1'b0, 1'b1, 4'd0, 1'b0), "reboot_operating");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/msrv32_trap_ctrl.md
Name: msrv32_trap_ctrl

Overview:
- Machine-mode trap sequencer for the RV32I core. It sits between the instruction decoder, the CSR file and the PC mux.
- Consumes the decoder's exception flags and the CSR interrupt-pending/enable bits, then decides trap entry and MRET return.
- Sequences the CSR updates (mepc, mcause, mstatus.MIE) and the PC source over a small FSM.
- Its combinational trap_taken_out feeds the decoder's trap_taken_in, which blocks the store write request.

Parameters:
- BOOT_HOLD_CYCLES, 1, number of cycles the FSM stays in RESET after reset deassertion (1..15).

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock.
- ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous assert, active-low.
- illegal_instr_in  input  1  from decoder.
- misaligned_instr_in  input  1  fetch target not 4-byte aligned.
- misaligned_load_in  input  1  from decoder.
- misaligned_store_in  input  1  from decoder.
- ecall_in  input  1  ECALL decoded.
- ebreak_in  input  1  EBREAK decoded.
- mret_in  input  1  MRET decoded.
- mie_in  input  1  mstatus.MIE.
- meie_in, mtie_in, msie_in  input  1 each  mie enable bits.
- meip_in, mtip_in, msip_in  input  1 each  mip pending bits.
- trap_taken_out  output  1  trap accepted this cycle (combinational).
- set_epc_out  output  1  CSR file loads mepc with current PC.
- set_cause_out  output  1  CSR file loads mcause.
- cause_out  output  4  mcause code field.
- i_or_e_out  output  1  mcause[31]: 1 = interrupt.
- mie_clear_out  output  1  copy MIE to MPIE, clear MIE.
- mie_set_out  output  1  restore MIE from MPIE.
- pc_src_out  output  2  00 BOOT, 01 EPC, 10 TRAP_VEC, 11 NEXT.
- flush_out  output  1  kill instruction in the pipeline register.
- instret_inc_out  output  1  instruction retired (minstret increment).

Behaviour:
- FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN. The state is registered; reset drives it to RESET asynchronously, including mid-trap.
- Reset values: pc_src_out=00, flush_out=1, every other output 0, cause register=0, i_or_e register=0, hold counter=0.
- RESET state:
  - Counts BOOT_HOLD_CYCLES clocks with pc_src=00 and flush=1, then moves to OPERATING.
- OPERATING state:
  - pc_src=11.
  - exc = illegal | misaligned_instr | misaligned_load | misaligned_store | ecall | ebreak.
  - irq = mie_in & ((meie&meip) | (msie&msip) | (mtie&mtip)).
  - trap_taken_out = exc | irq, combinational in this state only; 0 in every other state.
  - On trap_taken_out: capture cause and i_or_e, go to TRAP_TAKEN, instret_inc=0.
  - Else, on mret_in: go to TRAP_RETURN, instret_inc=1.
  - Else: instret_inc=1.
- Cause priority, highest first:
  - Interrupts: external 11, software 3, timer 7.
  - Exceptions: misaligned_instr 0, illegal 2, ebreak 3, ecall 11, misaligned_load 4, misaligned_store 6.
  - An enabled interrupt beats a simultaneous exception; the faulting instruction re-executes after return.
- TRAP_TAKEN state (exactly 1 cycle):
  - set_epc=1, set_cause=1, mie_clear=1, pc_src=10, flush=1.
  - cause_out/i_or_e_out show the captured values.
  - Returns to OPERATING.
- TRAP_RETURN state (exactly 1 cycle):
  - mie_set=1, pc_src=01, flush=1.
  - Returns to OPERATING.
- Simultaneous mret_in and exception/irq: the trap wins and MRET is discarded.
- Interrupts are never sampled outside OPERATING, so back-to-back trap entry is spaced by at least one OPERATING cycle.
- cause_out/i_or_e_out hold their last captured value between traps.

Optional Feature:
- Macro: MSRV32_WFI_STALL_EN.
- With the macro defined:
  - Adds port wfi_in (1 bit) and a state WAIT_IRQ.
  - wfi_in in OPERATING with no trap goes to WAIT_IRQ: pc_src=11, flush=0, instret_inc=0, and an internal stall_out (1 bit) holds the PC.
  - Leaves WAIT_IRQ to OPERATING when any (enable & pending) bit is set, regardless of mie_in.
  - The interrupt is then taken from OPERATING on the next cycle if mie_in=1.
- Without the macro: no wfi_in or stall_out ports, and the FSM has 4 states.

Decomposition:
- Package msrv32_trap_pkg holds:
  - state encoding constants;
  - pc_src codes (PC_BOOT, PC_EPC, PC_TRAP, PC_NEXT);
  - exception cause codes (CAUSE_INSTR_MISALIGN=0, CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_LOAD_MISALIGN=4, CAUSE_STORE_MISALIGN=6, CAUSE_ECALL_M=11);
  - interrupt codes (IRQ_SW=3, IRQ_TIMER=7, IRQ_EXT=11).
- Sub-module msrv32_trap_cause_enc: purely combinational priority encoder producing {valid, i_or_e, cause[3:0]}.

Test Plan:
- Reset release, BOOT_HOLD_CYCLES=1 -> one cycle pc_src=00 with flush=1, then pc_src=11 and instret_inc=1.
- illegal_instr_in=1 for one cycle in OPERATING -> trap_taken_out=1 same cycle; next cycle set_epc=set_cause=mie_clear=1, cause=2, i_or_e=0, pc_src=10; then OPERATING.
- misaligned_store_in=1 with mtie=mtip=1, mie_in=1 -> interrupt wins: cause=7, i_or_e=1.
- Same as above but mie_in=0 -> cause=6, i_or_e=0.
- mret_in=1 -> next cycle mie_set=1, pc_src=01, flush=1.
- mret_in=1 with ecall_in=1 -> trap path, cause=11, no mie_set.
- Reset asserted during TRAP_TAKEN -> all outputs return to reset values immediately (asynchronously), with no set_epc pulse afterwards.
